booth_r4_mul: RTL

//  Parametrised sequential radix-4 Booth multiplier; next generation of the team's radix-2 8-bit unit.

---
 rtl/booth_pkg.sv | 46 ++++
 rtl/booth_r4_recode.sv | 35 +++
 rtl/booth_r4_mul.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// ---------------------------------------------------------------------------
// booth_pkg
// Shared types and helpers for the radix-4 Booth multiplier.
//   state_t        : controller states (IDLE / CALC / DONE)
//   booth_digit_t  : recoded radix-4 digit {neg, one, two}
//   w2_of/iter_of  : internal operand width and digit count for a given WIDTH
//   booth_decode   : 3-bit multiplier window -> Booth digit
// ---------------------------------------------------------------------------
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_digit_t;

    // Two guard bits let one datapath handle both signed and unsigned operands.
    function automatic int w2_of(input int width);
        return width + 2;
    endfunction

    function automatic int iter_of(input int width);
        return (width + 2) / 2;
    endfunction

    // Window is {b[2i+1], b[2i], b[2i-1]}.
    function automatic booth_digit_t booth_decode(input logic [2:0] win);
        booth_digit_t d;
        d = '0;
        case (win)
            3'b001, 3'b010: d.one = 1'b1;
            3'b011:         d.two = 1'b1;
            3'b100:         begin d.neg = 1'b1; d.two = 1'b1; end
            3'b101, 3'b110: begin d.neg = 1'b1; d.one = 1'b1; end
            default:        d = '0;   // 000 and 111 are digit zero
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_r4_recode.sv
// ---------------------------------------------------------------------------
// booth_r4_recode
// Combinational radix-4 Booth recoder: turns one 3-bit multiplier window and
// the (already extended) multiplicand into a signed partial product.
// Ports:
//   win    in  3       {b[2i+1], b[2i], b[2i-1]}
//   mcand  in  W2      extended multiplicand (two's complement)
//   pp     out W2+1    partial product in {0, +-A, +-2A}
// ---------------------------------------------------------------------------
module booth_r4_recode
    import booth_pkg::*;
#(
    parameter int W2 = 10
) (
    input  logic [2:0]    win,
    input  logic [W2-1:0] mcand,
    output logic [W2:0]   pp
);

    booth_digit_t dig;
    logic [W2:0]  mag;

    always_comb begin
        dig = booth_decode(win);
        mag = '0;
        if (dig.one) begin
            mag = {mcand[W2-1], mcand};
        end else if (dig.two) begin
            mag = {mcand, 1'b0};
        end
        // mcand never reaches -2^(W2-1) thanks to the guard bits, so -2A fits.
        pp = dig.neg ? (~mag + 1'b1) : mag;
    end

endmodule

// File: rtl/booth_r4_mul.sv
// ---------------------------------------------------------------------------
// booth_r4_mul
// Sequential radix-4 Booth multiplier, one digit retired per clock.
// Optional feature macro: BOOTH_R4_ACC_EN (accumulate into product on done).
// Ports:
//   clk      in   1          rising-edge clock
//   rst_n    in   1          synchronous active-low reset
//   start    in   1          request; accepted in IDLE and DONE
//   sgn      in   1          1: signed operands, 0: unsigned
//   a, b     in   WIDTH      multiplicand / multiplier
//   acc_clr  in   1          (BOOTH_R4_ACC_EN only) clear product before adding
//   busy     out  1          operation in progress
//   done     out  1          one-cycle pulse, product valid
//   product  out  2*WIDTH    result, held until next completion
// ---------------------------------------------------------------------------
module booth_r4_mul
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef BOOTH_R4_ACC_EN
    input  logic                 acc_clr,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int W2    = w2_of(WIDTH);
    localparam int ITER  = iter_of(WIDTH);
    localparam int CNT_W = $clog2(ITER);
    localparam int HW    = W2 + 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [HW-1:0]        hi_q, hi_d;      // upper accumulator half
    logic [W2-1:0]        lo_q, lo_d;      // multiplier, product low bits shift in
    logic                 bm1_q, bm1_d;    // b[2i-1] of the current window
    logic [W2-1:0]        mcand_q, mcand_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
`ifdef BOOTH_R4_ACC_EN
    logic                 acc_clr_q, acc_clr_d;
`endif

    logic [W2:0]          pp;
    logic [HW-1:0]        sum;
    logic [2*WIDTH-1:0]   res;

    function automatic logic [W2-1:0] ext(input logic [WIDTH-1:0] x, input logic s);
        return s ? {{2{x[WIDTH-1]}}, x} : {2'b00, x};
    endfunction

    booth_r4_recode #(.W2(W2)) u_recode (
        .win   ({lo_q[1:0], bm1_q}),
        .mcand (mcand_q),
        .pp    (pp)
    );

    assign sum = hi_q + {pp[W2], pp};
    assign res = {hi_q[2*WIDTH-W2-1:0], lo_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        bm1_d     = bm1_q;
        mcand_d   = mcand_q;
        done_d    = 1'b0;
        product_d = product_q;
`ifdef BOOTH_R4_ACC_EN
        acc_clr_d = acc_clr_q;
`endif

        case (state_q)
            CALC: begin
                // Add digit at weight 4^i then shift the whole {hi,lo,b[-1]} right by 2.
                hi_d  = {{2{sum[HW-1]}}, sum[HW-1:2]};
                lo_d  = {sum[1:0], lo_q[W2-1:2]};
                bm1_d = lo_q[1];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
`ifdef BOOTH_R4_ACC_EN
                product_d = (acc_clr_q ? '0 : product_q) + res;
`else
                product_d = res;
`endif
                state_d = IDLE;
            end
            default: ;
        endcase

        // Start is honoured in IDLE and DONE; DONE -> CALC gives back-to-back ops.
        if (start && (state_q != CALC)) begin
            state_d = CALC;
            cnt_d   = '0;
            hi_d    = '0;
            lo_d    = ext(b, sgn);
            bm1_d   = 1'b0;
            mcand_d = ext(a, sgn);
`ifdef BOOTH_R4_ACC_EN
            acc_clr_d = acc_clr;
`endif
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            bm1_q     <= 1'b0;
            mcand_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
`ifdef BOOTH_R4_ACC_EN
            acc_clr_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            bm1_q     <= bm1_d;
            mcand_q   <= mcand_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
`ifdef BOOTH_R4_ACC_EN
            acc_clr_q <= acc_clr_d;
`endif
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule
